// File: rtl/imem_boot_loader.sv
// Boot loader: turns a framed UART byte stream into 32-bit instruction RAM writes.
// Frame = SYNC, CNT_LO, CNT_HI, 4*N little-endian data bytes, XOR checksum.
// The CPU is held in reset from SYNC until a frame passes its checksum.
module imem_boot_loader #(
    parameter int          ADDR_WIDTH = 10,
    parameter logic [7:0]  SYNC_BYTE  = 8'hA5,
    parameter logic [31:0] BASE_ADDR  = 32'h0
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [7:0]            rx_data_i,
    input  logic                  rx_valid_i,
    output logic                  imem_we_o,
    output logic [31:0]           imem_addr_o,
    output logic [31:0]           imem_wdata_o,
    output logic                  cpu_reset_o,
    output logic                  load_done_o,
    output logic                  load_err_o,
    output logic [ADDR_WIDTH:0]   words_loaded_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_CNT_LO, S_CNT_HI, S_DATA, S_CHECK, S_DONE, S_ERR
    } state_t;

    // Largest frame that fits the RAM without the address wrapping.
    localparam logic [31:0] MAX_WORDS = 32'd1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] ONE_W = {{ADDR_WIDTH{1'b0}}, 1'b1};

    state_t              state_q, state_d;
    logic [15:0]         cnt_q, cnt_d;
    logic [1:0]          idx_q, idx_d;
    logic [31:0]         buf_q, buf_d;      // word being assembled
    logic [31:0]         addr_q, addr_d;    // address of the next word
    logic [7:0]          chk_q, chk_d;
    logic [ADDR_WIDTH:0] words_q, words_d;
    logic                we_q, we_d;
    logic [31:0]         waddr_q, waddr_d;  // write port registers, held while the
    logic [31:0]         wdata_q, wdata_d;  // next word is already being assembled
    logic                cpu_rst_q, cpu_rst_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic [15:0]         new_cnt;
    logic [ADDR_WIDTH:0] words_nx;

    assign new_cnt  = {rx_data_i, cnt_q[7:0]};
    assign words_nx = words_q + ONE_W;

    // Next-state and datapath update; every byte is consumed only on rx_valid.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        buf_d     = buf_q;
        addr_d    = addr_q;
        chk_d     = chk_q;
        words_d   = words_q;
        we_d      = 1'b0;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        cpu_rst_d = cpu_rst_q;
        done_d    = done_q;
        err_d     = err_q;
        if (rx_valid_i) begin
            unique case (state_q)
                S_IDLE, S_DONE, S_ERR: begin
                    if (rx_data_i == SYNC_BYTE) begin
                        state_d   = S_CNT_LO;
                        cpu_rst_d = 1'b1;
                        done_d    = 1'b0;
                        err_d     = 1'b0;
                        words_d   = '0;
                        chk_d     = '0;
                        idx_d     = '0;
                        addr_d    = BASE_ADDR;
                    end
                end
                S_CNT_LO: begin
                    cnt_d[7:0] = rx_data_i;
                    state_d    = S_CNT_HI;
                end
                S_CNT_HI: begin
                    cnt_d = new_cnt;
                    idx_d = '0;
                    if (new_cnt == 16'd0) begin
                        state_d = S_CHECK;
                    end else if (32'(new_cnt) > MAX_WORDS) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_DATA;
                    end
                end
                S_DATA: begin
                    chk_d = chk_q ^ rx_data_i;
                    buf_d[{idx_q, 3'b000} +: 8] = rx_data_i;
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        we_d    = 1'b1;
                        waddr_d = addr_q;
                        wdata_d = {rx_data_i, buf_q[23:0]};
                        addr_d  = addr_q + 32'd4;
                        words_d = words_nx;
                        if (32'(words_nx) == 32'(cnt_q)) state_d = S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (rx_data_i == chk_q) begin
                        state_d   = S_DONE;
                        done_d    = 1'b1;
                        cpu_rst_d = 1'b0;
                    end else begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State register; reset aborts any frame and releases the CPU.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            buf_q     <= '0;
            addr_q    <= BASE_ADDR;
            chk_q     <= '0;
            words_q   <= '0;
            we_q      <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            cpu_rst_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            buf_q     <= buf_d;
            addr_q    <= addr_d;
            chk_q     <= chk_d;
            words_q   <= words_d;
            we_q      <= we_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            cpu_rst_q <= cpu_rst_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign imem_we_o      = we_q;
    assign imem_addr_o    = waddr_q;
    assign imem_wdata_o   = wdata_q;
    assign cpu_reset_o    = cpu_rst_q;
    assign load_done_o    = done_q;
    assign load_err_o     = err_q;
    assign words_loaded_o = words_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: frames built here, expected RAM writes queued in a
// scoreboard and popped by a monitor whenever the write strobe is seen.
module tb_imem_boot_loader;

    localparam int          AW   = 10;
    localparam logic [7:0]  SYNC = 8'hA5;
    localparam logic [31:0] BASE = 32'h0;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [7:0]    rx_data = '0;
    logic          rx_valid = 1'b0;
    logic          imem_we;
    logic [31:0]   imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_reset;
    logic          load_done;
    logic          load_err;
    logic [AW:0]   words_loaded;

    int checks = 0;
    int errors = 0;

    logic [63:0] sb[$];    // expected {addr, data}
    logic [7:0]  tx[$];    // bytes to send
    bit          txw[$];   // 1 if that byte completes a word
    logic [31:0] dq[$];    // data words of the next frame
    bit          prev_we = 1'b0;

    imem_boot_loader #(.ADDR_WIDTH(AW), .SYNC_BYTE(SYNC), .BASE_ADDR(BASE)) dut (
        .clk_i(clk), .reset_i(reset), .rx_data_i(rx_data), .rx_valid_i(rx_valid),
        .imem_we_o(imem_we), .imem_addr_o(imem_addr), .imem_wdata_o(imem_wdata),
        .cpu_reset_o(cpu_reset), .load_done_o(load_done), .load_err_o(load_err),
        .words_loaded_o(words_loaded)
    );

    always #5 clk = ~clk;

    // Write monitor: every strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (!reset && imem_we) begin
            logic [63:0] e;
            checks++;
            if (prev_we) begin
                errors++;
                $display("FAIL we_back_to_back: imem_we high two cycles in a row");
            end
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: addr %h data %h, none expected", imem_addr, imem_wdata);
            end else begin
                e = sb.pop_front();
                if ({imem_addr, imem_wdata} !== e) begin
                    errors++;
                    $display("FAIL write: got addr %h data %h, want addr %h data %h",
                             imem_addr, imem_wdata, e[63:32], e[31:0]);
                end
            end
        end
        prev_we = imem_we && !reset;
    end

    task automatic send_byte(input logic [7:0] b, input bit exp_we);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
        checks++;
        if (imem_we !== exp_we) begin
            errors++;
            $display("FAIL we_latency: byte %h imem_we %b want %b", b, imem_we, exp_we);
        end
    endtask

    task automatic send_stream(input int max_idle);
        while (tx.size() > 0) begin
            logic [7:0] b;
            bit w;
            b = tx.pop_front();
            w = txw.pop_front();
            send_byte(b, w);
            repeat ($urandom_range(max_idle, 0)) @(negedge clk);
        end
    endtask

    task automatic push_byte(input logic [7:0] b, input bit w);
        tx.push_back(b);
        txw.push_back(w);
    endtask

    // Queue a complete frame from dq; expected writes go to the scoreboard.
    task automatic build_frame(input bit bad_chk);
        logic [7:0] c;
        logic [15:0] n;
        c = '0;
        n = 16'(dq.size());
        push_byte(SYNC, 1'b0);
        push_byte(n[7:0], 1'b0);
        push_byte(n[15:8], 1'b0);
        for (int i = 0; i < dq.size(); i++) begin
            for (int k = 0; k < 4; k++) begin
                logic [7:0] b;
                b = dq[i][8*k +: 8];
                c ^= b;
                push_byte(b, k == 3);
            end
            sb.push_back({BASE + 32'(4 * i), dq[i]});
        end
        push_byte(bad_chk ? ~c : c, 1'b0);
        dq.delete();
    endtask

    task automatic check_flags(input string tag, input bit d, input bit e, input bit cr,
                               input int w);
        checks++;
        if (load_done !== d || load_err !== e || cpu_reset !== cr || words_loaded !== (AW+1)'(w)) begin
            errors++;
            $display("FAIL %s: done %b err %b cpu_reset %b words %0d, want %b %b %b %0d",
                     tag, load_done, load_err, cpu_reset, words_loaded, d, e, cr, w);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({imem_we, imem_addr, imem_wdata, cpu_reset, load_done, load_err, words_loaded} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: we %b addr %h data %h cr %b d %b e %b w %0d, want all 0",
                     imem_we, imem_addr, imem_wdata, cpu_reset, load_done, load_err, words_loaded);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        dq.push_back(32'h00520333);
        dq.push_back(32'h402184B3);
        build_frame(1'b0);
        send_byte(tx.pop_front(), txw.pop_front());
        check_flags("basic_loading", 1'b0, 1'b0, 1'b1, 0);
        send_stream(0);
        @(negedge clk);
        check_flags("basic_done", 1'b1, 1'b0, 1'b0, 2);
    endtask

    task automatic test_bad_chk();
        dq.push_back(32'h00520333);
        dq.push_back(32'h402184B3);
        build_frame(1'b1);
        send_stream(1);
        @(negedge clk);
        check_flags("bad_chk", 1'b0, 1'b1, 1'b1, 2);
    endtask

    task automatic test_count_edges();
        build_frame(1'b0);                    // count 0, checksum 00
        send_stream(0);
        check_flags("count_zero", 1'b1, 1'b0, 1'b0, 0);
        push_byte(SYNC, 1'b0);
        push_byte(8'h01, 1'b0);
        push_byte(8'h04, 1'b0);               // count 1025
        send_stream(0);
        check_flags("count_too_big", 1'b0, 1'b1, 1'b1, 0);
        for (int i = 0; i < (1 << AW); i++) dq.push_back($urandom());
        build_frame(1'b0);                    // exactly fills the RAM
        send_stream(0);
        check_flags("count_max", 1'b1, 1'b0, 1'b0, 1 << AW);
    endtask

    task automatic test_noise_sync_in_data();
        push_byte(8'h11, 1'b0);
        dq.push_back(32'hA5A500A5);
        dq.push_back(32'h12A53456);
        dq.push_back(32'hA5000000);
        build_frame(1'b0);
        send_stream(3);
        check_flags("sync_in_data", 1'b1, 1'b0, 1'b0, 3);
    endtask

    task automatic test_reset_mid();
        push_byte(SYNC, 1'b0);
        push_byte(8'h01, 1'b0);
        push_byte(8'h00, 1'b0);
        push_byte(8'h33, 1'b0);
        push_byte(8'h03, 1'b0);
        send_stream(0);
        check_flags("mid_before_reset", 1'b0, 1'b0, 1'b1, 0);
        test_reset();
        repeat (4) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL mid_reset_sb: %0d writes pending, want 0", sb.size());
        end
        dq.push_back(32'hDEADBEEF);
        dq.push_back(32'h00000013);
        build_frame(1'b0);
        send_stream(2);
        check_flags("mid_reload", 1'b1, 1'b0, 1'b0, 2);
    endtask

    task automatic test_restart();
        send_byte(SYNC, 1'b0);                // from DONE
        check_flags("restart_from_done", 1'b0, 1'b0, 1'b1, 0);
        push_byte(8'h01, 1'b0);
        push_byte(8'h00, 1'b0);
        push_byte(8'h00, 1'b0);
        push_byte(8'h00, 1'b0);
        push_byte(8'h00, 1'b0);
        push_byte(8'h01, 1'b1);
        sb.push_back({BASE, 32'h01000000});
        push_byte(8'h55, 1'b0);               // wrong checksum
        send_stream(0);
        check_flags("restart_err", 1'b0, 1'b1, 1'b1, 1);
        dq.push_back(32'hCAFEF00D);
        build_frame(1'b0);                    // from ERR
        send_byte(tx.pop_front(), txw.pop_front());
        check_flags("restart_from_err", 1'b0, 1'b0, 1'b1, 0);
        send_stream(0);
        check_flags("restart_reload", 1'b1, 1'b0, 1'b0, 1);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_bad_chk();
        test_count_edges();
        test_noise_sync_in_data();
        test_reset_mid();
        test_restart();
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d expected writes never seen", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
